reg_xfer_arbiter: RTL
=====================

// Module: reg_xfer_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for register-to-register moves over the shared 32-bit datapath bus.
//  Up to NREQ requesters each post a (src, dst) register pair; one winner is serviced at a time.
//  It drives the one-hot out-enables that put a register onto the bus, then the one-hot write enables of the 32-bit registers.
//  Sits between requesting control logic and the register bank; it never touches data itself.
// PARAMETERS
//  NREQ  4   number of requesters (>=2)
//  NREG  16  number of registers on the bus
//  AW    4   register index width, 2**AW >= NREG
// PORTS
//  clk        in   1        clock; all state changes on posedge
//  clr        in   1        reset, asynchronous, active-high
//  req        in   NREQ     transfer request, level, one bit per requester
//  src_sel    in   NREQ*AW  source index of requester i at [i*AW +: AW]
//  dst_sel    in   NREQ*AW  destination index of requester i at [i*AW +: AW]
//  grant      out  NREQ     one-hot, winner being serviced
//  done       out  NREQ     one-hot, 1-cycle pulse when winner's write has completed
//  reg_out    out  NREG     one-hot bus out-enable (source register drives bus)
//  reg_write  out  NREG     one-hot write enable into destination register
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  - Reset: clr high forces IDLE immediately; ptr=0; all outputs are 0 while clr is high and after release.
//  - The FSM has four states: IDLE -> DRIVE -> WRITE -> DONE -> IDLE. All outputs decode from registered state and latched fields only.
//  - IDLE: at a posedge with req!=0, pick winner w = first set bit scanning ptr, ptr+1, ... wrapping modulo NREQ.
//    On that same edge, latch w, src_sel[w] and dst_sel[w], then go to DRIVE. With req==0, stay in IDLE.
//  - DRIVE: grant[w]=1, reg_out[src]=1, reg_write=0 (bus settles).
//  - WRITE: grant[w]=1, reg_out[src]=1, reg_write[dst]=1. The destination captures the bus at the edge leaving WRITE.
//  - DONE: done[w]=1, grant=0, reg_out=0, reg_write=0. On the exit edge, ptr <= (w+1) mod NREQ.
//  - Latency: request accepted at edge k; DRIVE occupies k..k+1, WRITE k+1..k+2, and done is high k+2..k+3.
//    Next arbitration is at edge k+4, so throughput is one move per 4 cycles.
//  - req is ignored outside IDLE. A requester holding req through DONE is eligible again at the next IDLE edge, subject to rotation.
//  - Dropping req or changing src_sel/dst_sel after acceptance has no effect; the transfer completes on the latched values.
//  - src==dst is legal: it goes through the full sequence and the register rewrites its own value.
//  - An index >= NREG gives an all-zero reg_out or reg_write for that phase. The sequence still runs and done still pulses.
//  - clr asserted mid-transfer aborts it: no done pulse, and the destination may or may not have been written depending on the phase.
//  - grant, done, reg_out and reg_write are each zero or one-hot at all times. reg_write is never high outside WRITE.
// TESTING
//  1. Reset: clr=1 with req=4'b1111 -> grant/done/reg_out/reg_write/busy all 0. Release -> first winner is 0.
//  2. Single move: req[2]=1, src=3, dst=7 at edge k.
//     -> reg_out=16'h0008 during k..k+2 and reg_write=16'h0080 during k+1..k+2.
//     -> done=4'b0100 during k+2..k+3; R7 then equals the preloaded R3 value (e.g. 32'h11111111).
//  3. Rotation: req=4'b1111 held -> grants in order 0,1,2,3,0, each transfer 4 cycles, no requester starved.
//  4. Latch check: req[1]=1 src=5 dst=6, then change to src=9 dst=10 and drop req during DRIVE
//     -> move is still 5->6, and registers 9 and 10 are never enabled.
//  5. Abort: assert clr during WRITE -> all outputs 0 asynchronously, no done, busy=0, and ptr restarts at 0.
//  6. Out of range with NREG=12: dst=13 -> reg_write stays 0 for the whole transfer, and done still pulses.

Source files
------------

// File: rtl/reg_xfer_arbiter_if.sv
// reg_xfer_arbiter_if
//   Request/sequencing bundle between requesting control logic and the
//   register-move arbiter.
//   Requester side (master): req, src_sel, dst_sel.
//   Arbiter side   (slave):  grant, done, reg_out, reg_write, busy.
//   Field i of src_sel/dst_sel lives at [i*AW +: AW].
interface reg_xfer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NREG = 16,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] src_sel;
  logic [NREQ*AW-1:0] dst_sel;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [NREG-1:0]    reg_out;
  logic [NREG-1:0]    reg_write;
  logic               busy;

  modport master (
    output req, src_sel, dst_sel,
    input  grant, done, reg_out, reg_write, busy
  );

  modport slave (
    input  req, src_sel, dst_sel,
    output grant, done, reg_out, reg_write, busy
  );
endinterface

// File: rtl/reg_xfer_arbiter.sv
// reg_xfer_arbiter
//   Round-robin arbiter and sequencer for register-to-register moves over a
//   shared 32-bit bus. One winner at a time is walked through
//   IDLE -> DRIVE -> WRITE -> DONE -> IDLE. It only issues enables; data never
//   passes through this block.
// Ports
//   clk : clock, all state changes on posedge
//   clr : asynchronous active-high reset
//   bus : reg_xfer_arbiter_if.slave
//         req/src_sel/dst_sel in; grant/done/reg_out/reg_write/busy out
//         (grant, done, reg_out, reg_write are zero or one-hot)
module reg_xfer_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic               clk,
  input  logic               clr,
  reg_xfer_arbiter_if.slave  bus
);

  localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [WW-1:0]   ptr;
  logic [WW-1:0]   win;
  logic [AW-1:0]   src;
  logic [AW-1:0]   dst;

  logic            pick_found;
  logic [WW-1:0]   pick_idx;
  logic [AW-1:0]   pick_src;
  logic [AW-1:0]   pick_dst;
  int unsigned     cand;
  logic [WW-1:0]   ptr_next;

  // One-hot register decode; indices >= NREG simply match nothing.
  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] idx);
    reg_onehot = '0;
    for (int unsigned j = 0; j < NREG; j++) begin
      if (32'(idx) == j) reg_onehot[j] = 1'b1;
    end
  endfunction

  function automatic logic [NREQ-1:0] req_onehot(input logic [WW-1:0] idx);
    req_onehot = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (32'(idx) == j) req_onehot[j] = 1'b1;
    end
  endfunction

  // Rotating priority scan: ptr has highest priority, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_src   = '0;
    pick_dst   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand[WW-1:0];
        pick_src   = bus.src_sel[cand*AW +: AW];
        pick_dst   = bus.dst_sel[cand*AW +: AW];
      end
    end
  end

  always_comb begin
    if (32'(win) == NREQ - 1) ptr_next = '0;
    else                      ptr_next = win + 1'b1;
  end

  // Outputs are registered and loaded one state ahead so that each output
  // reflects the current state directly after the edge that entered it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      ptr           <= '0;
      win           <= '0;
      src           <= '0;
      dst           <= '0;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.reg_out   <= '0;
      bus.reg_write <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state         <= DRIVE;
            win           <= pick_idx;
            src           <= pick_src;
            dst           <= pick_dst;
            bus.grant     <= req_onehot(pick_idx);
            bus.reg_out   <= reg_onehot(pick_src);
            bus.reg_write <= '0;
            bus.done      <= '0;
            bus.busy      <= 1'b1;
          end
        end
        DRIVE: begin
          state         <= WRITE;
          bus.reg_write <= reg_onehot(dst);
        end
        WRITE: begin
          state         <= DONE;
          bus.grant     <= '0;
          bus.reg_out   <= '0;
          bus.reg_write <= '0;
          bus.done      <= req_onehot(win);
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= '0;
          bus.busy <= 1'b0;
          ptr      <= ptr_next;
        end
        default: begin
          state         <= IDLE;
          bus.grant     <= '0;
          bus.done      <= '0;
          bus.reg_out   <= '0;
          bus.reg_write <= '0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

  // src is only consumed through the registered reg_out load; keep it for
  // visibility of the latched transfer.
  logic unused_src;
  assign unused_src = ^src;

endmodule
